// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word per pc, presents it until retired,
// then advances to pc+4 or a decoder-selected target. Halts on bus or alignment errors.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned WaitW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ACK_TIMEOUT - 1);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

  state_t           r_state, w_state_d;
  logic [31:0]      r_pc, w_pc_d;
  logic [31:0]      r_instr, w_instr_d;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic             r_misalign, w_misalign_d;
  logic             r_bus_err, w_bus_err_d;
  // Keeps imem_req low until the first clock edge after reset release.
  logic             r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= Nop;
      r_wait     <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_instr    <= w_instr_d;
      r_wait     <= w_wait_d;
      r_misalign <= w_misalign_d;
      r_bus_err  <= w_bus_err_d;
      r_armed    <= 1'b1;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_instr_d    = r_instr;
    w_wait_d     = r_wait;
    w_misalign_d = r_misalign;
    w_bus_err_d  = r_bus_err;
    case (r_state)
      FETCH: begin
        if (r_armed) begin
          if (imem_ack) begin
            w_instr_d = imem_rdata;
            w_wait_d  = '0;
            w_state_d = VALID;
          end else if (r_wait == WaitLast) begin
            w_bus_err_d = 1'b1;
            w_state_d   = HALT;
          end else begin
            w_wait_d = r_wait + WaitW'(1);
          end
        end
      end
      VALID: begin
        if (!stall) begin
          if (pcsrc) begin
            if (pctarget[1:0] != 2'b00) begin
              w_misalign_d = 1'b1;
              w_state_d    = HALT;
            end else begin
              w_pc_d    = pctarget;
              w_state_d = FETCH;
            end
          end else begin
            w_pc_d    = r_pc + 32'd4;
            w_state_d = FETCH;
          end
        end
      end
      HALT:    w_state_d = HALT;
      default: w_state_d = HALT;
    endcase
  end

  assign imem_req     = (r_state == FETCH) && r_armed;
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign op           = r_instr[6:0];
  assign instr_valid  = (r_state == VALID);
  assign pc           = r_pc;
  assign pcplus4      = r_pc + 32'd4;
  assign misalign_err = r_misalign;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder pushes each returned word to a scoreboard,
// scenario tasks pop and compare as instructions become valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] pctarget = 32'h0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  int ack_delay = 0;
  bit ack_en = 1'b1;
  int rcnt = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .pcsrc(pcsrc),
    .pctarget(pctarget), .instr(instr), .op(op), .instr_valid(instr_valid), .pc(pc),
    .pcplus4(pcplus4), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1033;
  endfunction

  // Memory model: acks after ack_delay request cycles, pushes the word it returns.
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      rcnt     <= 0;
      imem_ack <= 1'b0;
    end else if (ack_en && rcnt == ack_delay) begin
      imem_ack   <= 1'b1;
      imem_rdata <= mem_word(imem_addr);
      sb.push_back(mem_word(imem_addr));
      rcnt       <= rcnt + 1;
    end else begin
      imem_ack   <= 1'b0;
      imem_rdata <= 32'hDEAD_BEEF;
      rcnt       <= rcnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      step();
      if (instr_valid) n = i;
    end
  endtask

  task automatic pop_exp(output logic [31:0] d, output bit ok);
    ok = sb.size() != 0;
    d  = ok ? sb.pop_front() : 32'hX;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    sb.delete();
    stall = 1'b0; pcsrc = 1'b0; pctarget = 32'h0;
    ack_en = 1'b1; ack_delay = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Retire n sequential instructions without checking them.
  task automatic skip_instrs(input int n);
    int w;
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_valid(w);
      pop_exp(d, ok);
      step();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h13); end
    checks++; if (op !== 7'h13) begin errors++; $display("FAIL reset_op got %h exp %h", op, 7'h13); end
    checks++; if ({imem_req, instr_valid, misalign_err, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {imem_req, instr_valid, misalign_err, bus_err});
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_before_edge got %b exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    int w;
    logic [31:0] d;
    logic [31:0] exp_pc;
    bit ok;
    do_reset();
    exp_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(w);
      pop_exp(d, ok);
      checks++; if (w != 1) begin errors++; $display("FAIL seq_latency got %0d exp 1", w); end
      checks++; if (!ok || instr !== d || instr !== mem_word(exp_pc)) begin
        errors++; $display("FAIL seq_instr got %h exp %h", instr, mem_word(exp_pc));
      end
      checks++; if (op !== d[6:0]) begin errors++; $display("FAIL seq_op got %h exp %h", op, d[6:0]); end
      checks++; if (pc !== exp_pc || pcplus4 !== exp_pc + 32'd4) begin
        errors++; $display("FAIL seq_pc got %h/%h exp %h/%h", pc, pcplus4, exp_pc, exp_pc + 32'd4);
      end
      step();
      exp_pc = exp_pc + 32'd4;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++; $display("FAIL seq_next got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                           instr_valid, imem_req, imem_addr, exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] d;
    bit ok;
    do_reset();
    skip_instrs(1);
    stall = 1'b1;
    wait_valid(w);
    pop_exp(d, ok);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h4 || !ok || instr !== d) begin
        errors++; $display("FAIL stall_hold got v=%b req=%b pc=%h instr=%h exp v=1 req=0 pc=4 instr=%h",
                           instr_valid, imem_req, pc, instr, d);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL stall_release got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    int w;
    logic [31:0] d;
    bit ok;
    do_reset();
    skip_instrs(2);
    wait_valid(w);
    pop_exp(d, ok);
    pcsrc = 1'b1; pctarget = 32'h40;
    step();
    checks++; if (imem_addr !== 32'h40 || pcplus4 !== 32'h44 || imem_req !== 1'b1) begin
      errors++; $display("FAIL branch_taken got addr=%h p4=%h req=%b exp 40/44/1", imem_addr, pcplus4, imem_req);
    end
    // A misaligned target presented outside the retire edge must be ignored.
    pctarget = 32'h22;
    wait_valid(w);
    pcsrc = 1'b0; pctarget = 32'h0;
    pop_exp(d, ok);
    checks++; if (misalign_err !== 1'b0 || pc !== 32'h40 || !ok || instr !== mem_word(32'h40)) begin
      errors++; $display("FAIL branch_fetch got mis=%b pc=%h instr=%h exp 0/40/%h",
                         misalign_err, pc, instr, mem_word(32'h40));
    end
    pcsrc = 1'b1; pctarget = 32'hFFFF_FFFC;
    step();
    pcsrc = 1'b0;
    wait_valid(w);
    pop_exp(d, ok);
    checks++; if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0 || instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_top got pc=%h p4=%h exp fffffffc/0", pc, pcplus4);
    end
    step();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_next got addr=%h req=%b exp 0/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_wait_states();
    int w;
    logic [31:0] d;
    bit ok;
    do_reset();
    ack_delay = 3;
    wait_valid(w);
    pop_exp(d, ok);
    checks++; if (w != 4) begin errors++; $display("FAIL wait_latency got %0d exp 4", w); end
    checks++; if (!ok || instr !== mem_word(32'h0) || bus_err !== 1'b0) begin
      errors++; $display("FAIL wait_capture got instr=%h be=%b exp %h/0", instr, bus_err, mem_word(32'h0));
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    ack_en = 1'b0;
    repeat (14) step();
    checks++; if (bus_err !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL timeout_early got be=%b req=%b exp 0/1", bus_err, imem_req);
    end
    step();
    checks++; if (bus_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_halt got be=%b req=%b v=%b exp 1/0/0", bus_err, imem_req, instr_valid);
    end
    ack_en = 1'b1;
    repeat (3) step();
    checks++; if (bus_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL timeout_sticky got be=%b req=%b pc=%h exp 1/0/0", bus_err, imem_req, pc);
    end
  endtask

  task automatic test_misalign();
    int w;
    logic [31:0] d;
    bit ok;
    do_reset();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_cleared got %b exp 0", bus_err); end
    wait_valid(w);
    pop_exp(d, ok);
    pcsrc = 1'b1; pctarget = 32'h22;
    step();
    checks++; if (misalign_err !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL misalign got mis=%b pc=%h req=%b v=%b exp 1/0/0/0",
                         misalign_err, pc, imem_req, instr_valid);
    end
    pcsrc = 1'b0;
    repeat (3) step();
    checks++; if (misalign_err !== 1'b1 || instr !== mem_word(32'h0) || imem_req !== 1'b0) begin
      errors++; $display("FAIL misalign_halt got mis=%b instr=%h req=%b exp 1/%h/0",
                         misalign_err, instr, imem_req, mem_word(32'h0));
    end
  endtask

  task automatic test_reset_midfetch();
    int w;
    logic [31:0] d;
    bit ok;
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_cleared got %b exp 0", misalign_err); end
    skip_instrs(4);
    ack_en = 1'b0;
    step(); step();
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      errors++; $display("FAIL midfetch_addr got %h req=%b exp 10/1", imem_addr, imem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || instr !== 32'h13 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h instr=%h req=%b v=%b exp 0/13/0/0",
                         pc, instr, imem_req, instr_valid);
    end
    ack_en = 1'b1;
    sb.delete();
    step(); step();
    checks++; if (instr !== 32'h13 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL ack_in_reset got instr=%h v=%b exp 13/0", instr, instr_valid);
    end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL restart got req=%b addr=%h exp 1/0", imem_req, imem_addr);
    end
    wait_valid(w);
    pop_exp(d, ok);
    checks++; if (w != 1 || !ok || instr !== mem_word(32'h0) || pc !== 32'h0) begin
      errors++; $display("FAIL restart_fetch got n=%0d instr=%h pc=%h exp 1/%h/0", w, instr, pc, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wait_states();
    test_timeout();
    test_misalign();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: ACK_TIMEOUT, 15, maximum wait cycles for imem_ack before a bus error.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address; equals pc.
REQ-007 imem_ack  in  1  memory has returned the word on imem_rdata; sampled only while imem_req=1.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 stall  in  1  downstream hold; while high, the current instruction stays presented.
REQ-010 pcsrc  in  1  from the main decoder; 1 selects pctarget.
REQ-011 pctarget  in  32  branch/jump target.
REQ-012 instr  out  32  registered instruction word.
REQ-013 op  out  7  instr[6:0], fed to the main decoder.
REQ-014 instr_valid  out  1  instr/op/pc describe a fetched instruction.
REQ-015 pc  out  32  address of instr.
REQ-016 pcplus4  out  32  pc+4, modulo 2^32.
REQ-017 misalign_err  out  1  sticky; a taken target had pctarget[1:0]!=0.
REQ-018 bus_err  out  1  sticky; imem_ack timed out.

Function
REQ-019 FSM states SHALL be FETCH, VALID and HALT.
REQ-020 FETCH: imem_req=1 and instr_valid=0; a wait counter increments each cycle without ack.
REQ-021 FETCH with imem_ack=1 at an edge: instr<=imem_rdata, wait counter<=0, go to VALID; zero-wait ack on the first request cycle is legal, giving 1-cycle fetch latency.
REQ-022 FETCH with no ack for ACK_TIMEOUT consecutive cycles: bus_err<=1, go to HALT.
REQ-023 VALID: imem_req=0, instr_valid=1.
REQ-024 VALID with stall=1: hold pc, instr and state; pcsrc/pctarget are ignored.
REQ-025 VALID with stall=0 (retire edge): next pc = pcsrc ? pctarget : pc+4, go to FETCH.
REQ-026 Retire with pcsrc=1 and pctarget[1:0]!=0: pc unchanged, misalign_err<=1, go to HALT.
REQ-027 HALT: imem_req=0, instr_valid=0, pc and instr frozen; exit only by reset.
REQ-028 pc arithmetic SHALL wrap: pc=32'hFFFF_FFFC retires to 32'h0000_0000 when not taken.
REQ-029 imem_addr SHALL be stable for the whole request; a new address is presented only after retirement.
REQ-030 op SHALL be combinational from instr and SHALL equal instr[6:0] even when instr_valid=0.
REQ-031 pcsrc and pctarget SHALL be sampled only at the retire edge.

Reset
REQ-032 While rst_n=0, outputs SHALL immediately take: pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign_err=0, bus_err=0, wait counter=0.
REQ-033 State SHALL be FETCH after reset release, with imem_req=1 on the first cycle after the first rising edge at which rst_n=1.
REQ-034 Reset asserted mid-fetch or in HALT SHALL abort the operation; a late imem_ack arriving during reset is ignored.

Verification
REQ-035 Sequential fetch: ack on every request, stall=0, pcsrc=0 -> pc sequence 0,4,8,C; instr_valid alternates 0/1; op matches rdata[6:0].
REQ-036 Taken branch: at pc=8, pcsrc=1, pctarget=32'h40 -> next imem_addr=32'h40, pcplus4=32'h44.
REQ-037 Stall: stall=1 for 3 cycles in VALID at pc=4 -> instr, pc and instr_valid=1 hold, no imem_req; release -> fetch at 8.
REQ-038 Wait states and timeout: ack after 3 cycles -> capture succeeds; no ack for 15 cycles -> bus_err=1, HALT, imem_req=0.
REQ-039 Misalign: pcsrc=1, pctarget=32'h22 -> misalign_err=1, pc unchanged, HALT until reset.
REQ-040 Reset mid-fetch at pc=32'h10 -> pc=RESET_PC and instr=NOP asynchronously; fetch restarts at RESET_PC.
